vga_hexmon: RTL and testbench
=============================

VGA_HEXMON -- requirements
Module: vga_hexmon

Interface
REQ-001 SHALL have parameter H_TOTAL, default 858, pixel clocks per line.
REQ-002 SHALL have parameter H_SYNC, default 62, hsync width in pixel clocks, starting at hcount 0.
REQ-003 SHALL have parameter H_ACT_BEG, default 128, first active pixel.
REQ-004 SHALL have parameter H_ACT, default 720, active pixels per line.
REQ-005 SHALL have parameters V_TOTAL 525, V_SYNC 6, V_ACT_BEG 30, V_ACT 480: line equivalents of REQ-001..004.
REQ-006 SHALL have parameters HS_POL 0 and VS_POL 1: asserted sync level (0 = negative).
REQ-007 SHALL have parameter NCH, default 4, range 1..8, displayed channel rows.
REQ-008 SHALL have parameter DIGITS, default 8, range 1..8, hex digits per channel (LS nibbles of each word).
REQ-009 SHALL have parameters TEXT_X 240 and TEXT_Y 96: top-left of text area in hcount/vcount coordinates.
REQ-010 SHALL have parameter LZB, default 0; 1 enables leading-zero blanking.
REQ-011 SHALL have parameter FG, width 6*NCH, default all 6'b111111; channel n colour at [6n+5:6n], bit order {g,r,b}.
REQ-012 SHALL have parameter BG, default 6'b000001, active-area background colour.
REQ-013 clk  in  1  pixel clock.
REQ-014 reset  in  1  synchronous, active-high reset.
REQ-015 clk_en  in  1  pixel enable; all state advances only when high.
REQ-016 values  in  32*NCH  channel words; channel n at [32n+31:32n].
REQ-017 hide  in  NCH  per-channel blanking of the whole row.
REQ-018 hs, vs  out  1 each  syncs at the REQ-006 polarity.
REQ-019 de  out  1  data enable.
REQ-020 r, g, b  out  2 each  colour.
REQ-021 frame  out  1  one-cycle snapshot strobe.

Function
REQ-022 hcount SHALL count 0..H_TOTAL-1 on each clk_en and wrap to 0; vcount SHALL increment only on that wrap, 0..V_TOTAL-1, then wrap to 0.
REQ-023 All outputs SHALL be registered and reflect the (hcount, vcount) of the previous clk_en cycle (latency 1 clk_en).
REQ-024 hs asserted iff hcount < H_SYNC; vs asserted iff vcount < V_SYNC.
REQ-025 de SHALL be 1 iff H_ACT_BEG <= hcount < H_ACT_BEG+H_ACT and V_ACT_BEG <= vcount < V_ACT_BEG+V_ACT.
REQ-026 Snapshot: on the clk_en cycle with hcount=0 and vcount=0, values and hide SHALL be latched into shadow registers and frame pulsed high for that one cycle; rendering uses shadow only (frame-coherent, no tearing).
REQ-027 Text geometry: x=hcount-TEXT_X, y=vcount-TEXT_Y; channel row = y/64, digit = x/32 (digit 0 = most significant displayed nibble), cell column = (x mod 32)/8, cell row = (y mod 64)/8.
REQ-028 Glyph pixel on only when x>=0, y>=0, row<NCH, digit<DIGITS, cell column<=2, cell row<=4, and segment mapping holds: row0 {a|f, a, a|b}; row1 {f, -, b}; row2 {f|e, g, b|c}; row3 {e, -, c}; row4 {d|e, d, d|c}; standard 7-seg encoding for 0-F.
REQ-029 A hidden channel (shadow hide bit) SHALL render no glyph pixels.
REQ-030 LZB=1: digits left of the first nonzero digit SHALL be blank; the last digit always shown (value 0 shows one "0").
REQ-031 Colour: glyph pixel and de -> FG of that channel; de and no glyph -> BG; de=0 -> 0.
REQ-032 clk_en low: all counters, shadows and outputs hold; frame SHALL be 0 on cycles where clk_en is low.

Reset
REQ-033 reset high at a clk edge SHALL set hcount=vcount=0, shadows=0, de=0, frame=0, r=g=b=0, hs=~HS_POL, vs=~VS_POL, regardless of clk_en.
REQ-034 After reset release, the first clk_en cycle SHALL be treated as hcount=0, vcount=0 (snapshot + frame pulse).

Verification
REQ-035 Defaults, free-run clk_en=1 -> hs low 62 of 858 clocks, vs high 6 of 525 lines, de high 720x480 per frame, frame period 450450 clocks.
REQ-036 values ch0=32'h0000A5C3 changed to 32'h12345678 mid-frame -> current frame draws 0000A5C3 in white, next frame 12345678.
REQ-037 LZB=1, ch1=32'h00000000, ch2=32'h00000F00 -> row1 shows single "0" at digit 7; row2 shows "F00" at digits 5..7.
REQ-038 hide=4'b0100 -> row 2 only BG colour 6'b000001 over text area; other rows unaffected.
REQ-039 clk_en toggled 1-of-3 -> output sequence identical to REQ-035 sampled on enabled cycles; frame never high on disabled cycles.
REQ-040 reset asserted mid-line (hcount=400, vcount=200) -> next cycle outputs at reset values; after release frame pulses on first clk_en.

Source files
------------

// File: rtl/vga_hexmon.sv
// VGA timing generator with a hex-digit overlay that shows NCH 32-bit channel words
// as seven-segment glyphs, using a snapshot of the inputs taken at the start of each frame.
module vga_hexmon #(
  parameter int H_TOTAL   = 858,
  parameter int H_SYNC    = 62,
  parameter int H_ACT_BEG = 128,
  parameter int H_ACT     = 720,
  parameter int V_TOTAL   = 525,
  parameter int V_SYNC    = 6,
  parameter int V_ACT_BEG = 30,
  parameter int V_ACT     = 480,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b1,
  parameter int NCH       = 4,
  parameter int DIGITS    = 8,
  parameter int TEXT_X    = 240,
  parameter int TEXT_Y    = 96,
  parameter bit LZB       = 1'b0,
  parameter logic [6*NCH-1:0] FG = {NCH{6'b111111}},
  parameter logic [5:0]       BG = 6'b000001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [32*NCH-1:0] values,
  input  logic [NCH-1:0]    hide,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b,
  output logic              frame
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount;
  logic [32*NCH-1:0] shadow_values;
  logic [NCH-1:0]    shadow_hide;

  int          xi, yi, row, dig, col, crow, nib;
  logic [31:0] word;
  logic [3:0]  nibble;
  logic [5:0]  fg, colour;
  logic        hid, lead_nz, pix, glyph, active;
  logic        sa, sb, sc, sd, se, sf, sg;

  // Segment bits ordered {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h7E;  4'h1: seg7 = 7'h30;  4'h2: seg7 = 7'h6D;  4'h3: seg7 = 7'h79;
      4'h4: seg7 = 7'h33;  4'h5: seg7 = 7'h5B;  4'h6: seg7 = 7'h5F;  4'h7: seg7 = 7'h70;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h7B;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h1F;
      4'hC: seg7 = 7'h4E;  4'hD: seg7 = 7'h3D;  4'hE: seg7 = 7'h4F;  default: seg7 = 7'h47;
    endcase
  endfunction

  always_comb begin
    xi   = int'(hcount) - TEXT_X;
    yi   = int'(vcount) - TEXT_Y;
    row  = yi / 64;
    dig  = xi / 32;
    col  = (xi % 32) / 8;
    crow = (yi % 64) / 8;
    nib  = DIGITS - 1 - dig;

    word = '0;
    hid  = 1'b0;
    fg   = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (row == ch) begin
        word = shadow_values[32*ch +: 32];
        hid  = shadow_hide[ch];
        fg   = FG[6*ch +: 6];
      end
    end

    // lead_nz: some displayed nibble at or above this position is nonzero
    nibble  = '0;
    lead_nz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k == nib) nibble = word[4*k +: 4];
      if (k >= nib && word[4*k +: 4] != 4'h0) lead_nz = 1'b1;
    end

    {sa, sb, sc, sd, se, sf, sg} = seg7(nibble);
    case (crow)
      0:       pix = (col == 0) ? (sa | sf) : (col == 1) ? sa : (sa | sb);
      1:       pix = (col == 0) ? sf        : (col == 1) ? 1'b0 : sb;
      2:       pix = (col == 0) ? (sf | se) : (col == 1) ? sg : (sb | sc);
      3:       pix = (col == 0) ? se        : (col == 1) ? 1'b0 : sc;
      4:       pix = (col == 0) ? (sd | se) : (col == 1) ? sd : (sd | sc);
      default: pix = 1'b0;
    endcase

    glyph = (xi >= 0) && (yi >= 0) && (row < NCH) && (dig < DIGITS) &&
            (col <= 2) && (crow <= 4) && !hid &&
            (!LZB || lead_nz || nib == 0) && pix;

    active = (int'(hcount) >= H_ACT_BEG) && (int'(hcount) < H_ACT_BEG + H_ACT) &&
             (int'(vcount) >= V_ACT_BEG) && (int'(vcount) < V_ACT_BEG + V_ACT);

    if (!active)    colour = '0;
    else if (glyph) colour = fg;
    else            colour = BG;
  end

  // Outputs describe the position being left behind, so they lag the counters by one enable
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount        <= '0;
      vcount        <= '0;
      shadow_values <= '0;
      shadow_hide   <= '0;
      hs            <= ~HS_POL;
      vs            <= ~VS_POL;
      de            <= 1'b0;
      r             <= '0;
      g             <= '0;
      b             <= '0;
      frame         <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (clk_en) begin
        if (int'(hcount) == H_TOTAL - 1) begin
          hcount <= '0;
          if (int'(vcount) == V_TOTAL - 1) vcount <= '0;
          else                              vcount <= vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end

        if (hcount == '0 && vcount == '0) begin
          shadow_values <= values;
          shadow_hide   <= hide;
          frame         <= 1'b1;
        end

        hs <= (int'(hcount) < H_SYNC) ? HS_POL : ~HS_POL;
        vs <= (int'(vcount) < V_SYNC) ? VS_POL : ~VS_POL;
        de <= active;
        g  <= colour[5:4];
        r  <= colour[3:2];
        b  <= colour[1:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_hexmon.sv
// Directed bench for vga_hexmon on a reduced raster; two instances differ only in
// leading-zero blanking so both renderings are checked from one stimulus stream.
module tb_vga_hexmon;

  localparam int NCH = 3;

  logic              clk;
  logic              reset;
  logic              clk_en;
  logic [32*NCH-1:0] values;
  logic [NCH-1:0]    hide;
  logic              hs0, vs0, de0, frame0, hs1, vs1, de1, frame1;
  logic [1:0]        r0, g0, b0, r1, g1, b1;

  int compared   = 0;
  int mismatched = 0;
  int ph = 0, pv = 0, lh = 0, lv = 0;
  bit last_valid = 1'b0;

  localparam logic [5:0] WHITE = 6'b111111;
  localparam logic [5:0] BGC   = 6'b000001;
  localparam logic [5:0] RED   = 6'b110000;
  localparam logic [5:0] GREEN = 6'b001100;
  localparam logic [5:0] BLACK = 6'b000000;

  vga_hexmon #(
    .H_TOTAL(136), .H_SYNC(3), .H_ACT_BEG(4), .H_ACT(130),
    .V_TOTAL(196), .V_SYNC(2), .V_ACT_BEG(2), .V_ACT(193),
    .NCH(NCH), .DIGITS(4), .TEXT_X(6), .TEXT_Y(2), .LZB(1'b0),
    .FG({6'b110000, 6'b001100, 6'b111111})
  ) dut0 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .values(values), .hide(hide),
    .hs(hs0), .vs(vs0), .de(de0), .r(r0), .g(g0), .b(b0), .frame(frame0)
  );

  vga_hexmon #(
    .H_TOTAL(136), .H_SYNC(3), .H_ACT_BEG(4), .H_ACT(130),
    .V_TOTAL(196), .V_SYNC(2), .V_ACT_BEG(2), .V_ACT(193),
    .NCH(NCH), .DIGITS(4), .TEXT_X(6), .TEXT_Y(2), .LZB(1'b1),
    .FG({6'b110000, 6'b001100, 6'b111111})
  ) dut1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .values(values), .hide(hide),
    .hs(hs1), .vs(vs1), .de(de1), .r(r1), .g(g1), .b(b1), .frame(frame1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed rgb %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock; the bench tracks which raster position the DUT consumes on that edge
  task automatic applyStimulus(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
    if (reset) begin
      ph = 0; pv = 0; last_valid = 1'b0;
    end else if (en) begin
      lh = ph; lv = pv; last_valid = 1'b1;
      if (ph == 135) begin
        ph = 0;
        pv = (pv == 195) ? 0 : pv + 1;
      end else begin
        ph = ph + 1;
      end
    end
  endtask

  // Advance with clk_en high until the outputs describe position (th, tv)
  task automatic goto_pos(input int th, input int tv);
    int guard;
    guard = 0;
    if (!(last_valid && lh == th && lv == tv)) begin
      while (!(ph == th && pv == tv)) begin
        applyStimulus(1'b1);
        guard++;
        if (guard > 60000) begin
          $display("[TB] FAIL goto_pos(%0d,%0d): cycle budget exhausted", th, tv);
          $fatal(1, "[TB] cycle budget");
        end
      end
      applyStimulus(1'b1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    clk_en = 1'b1;
    hide   = '0;
    values = {32'h00000F00, 32'h00000000, 32'h0000A5C3};

    applyStimulus(1'b1);
    applyStimulus(1'b1);
    check_bit("reset_hs", hs0, 1'b1);
    check_bit("reset_vs", vs0, 1'b0);
    check_bit("reset_de", de0, 1'b0);
    check_bit("reset_frame", frame0, 1'b0);
    check_rgb("reset_rgb", {r0, g0, b0}, BLACK);

    reset = 1'b0;
    goto_pos(0, 0);
    check_bit("f1_frame_pulse", frame0, 1'b1);
    check_bit("f1_hs_0", hs0, 1'b0);
    check_bit("f1_vs_0", vs0, 1'b1);
    check_bit("f1_de_0", de0, 1'b0);
    goto_pos(1, 0);
    check_bit("f1_frame_drop", frame0, 1'b0);
    goto_pos(2, 0);
    check_bit("hs_last_sync", hs0, 1'b0);
    goto_pos(3, 0);
    check_bit("hs_after_sync", hs0, 1'b1);
    goto_pos(5, 1);
    check_bit("de_vblank", de0, 1'b0);
    check_bit("vs_last_sync", vs0, 1'b1);
    goto_pos(5, 2);
    check_bit("de_first_line", de0, 1'b1);
    check_bit("vs_after_sync", vs0, 1'b0);
    check_rgb("bg_left_of_text", {r0, g0, b0}, BGC);

    // Row 0 shows A5C3 in white
    goto_pos(17, 5);
    check_rgb("ch0_A_seg_a", {r0, g0, b0}, WHITE);
    check_rgb("ch0_A_seg_a_lzb", {r1, g1, b1}, WHITE);
    goto_pos(33, 5);
    check_rgb("cell_col3_blank", {r0, g0, b0}, BGC);
    goto_pos(41, 13);
    check_rgb("ch0_5_seg_f", {r0, g0, b0}, WHITE);
    goto_pos(57, 13);
    check_rgb("ch0_5_no_b", {r0, g0, b0}, BGC);
    goto_pos(113, 21);
    check_rgb("ch0_3_seg_g", {r0, g0, b0}, WHITE);
    goto_pos(105, 29);
    check_rgb("ch0_3_no_e", {r0, g0, b0}, BGC);
    goto_pos(17, 37);
    check_rgb("ch0_A_no_d", {r0, g0, b0}, BGC);
    goto_pos(49, 37);
    check_rgb("ch0_5_seg_d", {r0, g0, b0}, WHITE);

    // Inputs change mid-frame; the current frame must keep the snapshot
    values[31:0] = 32'h12345678;
    hide         = 3'b100;
    goto_pos(17, 41);
    check_rgb("no_tear_A_no_d", {r0, g0, b0}, BGC);

    goto_pos(17, 69);
    check_rgb("ch1_zero_red", {r0, g0, b0}, RED);
    check_rgb("ch1_lzb_blank", {r1, g1, b1}, BGC);
    goto_pos(113, 69);
    check_rgb("ch1_lzb_last0", {r1, g1, b1}, RED);
    goto_pos(17, 133);
    check_rgb("ch2_lead0_green", {r0, g0, b0}, GREEN);
    check_rgb("ch2_lzb_lead_blank", {r1, g1, b1}, BGC);
    goto_pos(49, 133);
    check_rgb("ch2_lzb_F_seg_a", {r1, g1, b1}, GREEN);
    goto_pos(133, 133);
    check_bit("de_last_pixel", de0, 1'b1);
    goto_pos(134, 133);
    check_bit("de_past_line", de0, 1'b0);
    goto_pos(49, 165);
    check_rgb("ch2_lzb_F_no_d", {r1, g1, b1}, BGC);
    goto_pos(81, 165);
    check_rgb("ch2_lzb_inner0_d", {r1, g1, b1}, GREEN);
    goto_pos(10, 194);
    check_bit("de_last_line", de0, 1'b1);
    goto_pos(10, 195);
    check_bit("de_past_frame", de0, 1'b0);

    // Second frame picks up 12345678 (shown as 5678) and the row-2 hide
    goto_pos(0, 0);
    check_bit("f2_frame_pulse", frame0, 1'b1);
    check_bit("f2_vs", vs0, 1'b1);
    goto_pos(105, 29);
    check_rgb("f2_ch0_8_seg_e", {r0, g0, b0}, WHITE);
    goto_pos(17, 41);
    check_rgb("f2_ch0_5_seg_d", {r0, g0, b0}, WHITE);
    goto_pos(17, 69);
    check_rgb("f2_ch1_unhidden", {r0, g0, b0}, RED);
    goto_pos(17, 133);
    check_rgb("f2_ch2_hidden", {r0, g0, b0}, BGC);
    goto_pos(49, 133);
    check_rgb("f2_ch2_hidden_lzb", {r1, g1, b1}, BGC);

    // Reset mid-line with clk_en low, then a 1-of-3 enable pattern
    goto_pos(100, 140);
    reset = 1'b1;
    applyStimulus(1'b0);
    check_bit("midreset_hs", hs0, 1'b1);
    check_bit("midreset_vs", vs0, 1'b0);
    check_bit("midreset_de", de0, 1'b0);
    check_rgb("midreset_rgb", {r0, g0, b0}, BLACK);
    check_bit("midreset_frame", frame0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0);
    check_bit("post_reset_idle_frame", frame0, 1'b0);
    applyStimulus(1'b1);
    check_bit("post_reset_frame", frame0, 1'b1);
    check_bit("post_reset_hs", hs0, 1'b0);
    applyStimulus(1'b0);
    check_bit("en_low_frame_clear", frame0, 1'b0);
    check_bit("en_low_hs_hold", hs0, 1'b0);
    check_bit("en_low_vs_hold", vs0, 1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    check_bit("slow_h1_hs", hs0, 1'b0);
    check_bit("slow_h1_frame", frame0, 1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    check_bit("slow_h3_hs", hs0, 1'b1);
    applyStimulus(1'b0);
    check_bit("slow_hold_hs", hs0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
